// File: rtl/hacd_pkg.sv
// rtl/hacd_pkg.sv - shared constants, state encoding and read packet types for the compress/decompress read manager
package hacd_pkg;

    localparam int LINE_BYTES = 64;
    localparam int PAGE_LINES = 64;
    localparam int ADDR_W     = 48;
    localparam int DATA_W     = 512;
    localparam int CNT_W      = 7;
    localparam int LINE_OFS   = $clog2(LINE_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_WAIT_RSP = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_DONE     = 3'd4
    } rd_state_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
    } axi_rd_reqpkt_t;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
        logic              err;
    } axi_rd_rsppkt_t;

    // Byte address of line idx within a line-aligned region starting at base.
    function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [CNT_W-1:0]  idx);
        return base + {{(ADDR_W-CNT_W-LINE_OFS){1'b0}}, idx, {LINE_OFS{1'b0}}};
    endfunction

endpackage

// File: rtl/hawk_linebuf2.sv
// rtl/hawk_linebuf2.sv - two-entry line FIFO between the read return channel and the line stream
module hawk_linebuf2 #(
    parameter int WIDTH = 512
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    input  logic             ready,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             pop;
    logic             push_ok;

    assign valid   = (count != 2'd0);
    assign pop     = valid & ready;
    // A push into a full buffer is only accepted when the head leaves in the same cycle.
    assign push_ok = push & ((count != 2'd2) | pop);
    // Head data is forced to zero when empty so the stream is quiet in reset and idle.
    assign data    = valid ? mem[rd_ptr] : '0;

    // Pointer and occupancy bookkeeping; push and pop together leave count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push_ok} - {1'b0, pop};
        end
    end

    // Storage carries no reset; its contents are never visible while empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/hawk_cmpdcmp_rd_mngr.sv
// rtl/hawk_cmpdcmp_rd_mngr.sv - fetches one line or one page of source lines and streams them to the codec
module hawk_cmpdcmp_rd_mngr
    import hacd_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rd_trigger_i,
    input  logic              comp_decomp_i,
    input  logic [ADDR_W-1:0] src_addr_i,
    output logic              rd_req_valid_o,
    output logic [ADDR_W-1:0] rd_req_addr_o,
    input  logic              rd_req_ready_i,
    input  logic              rd_rsp_valid_i,
    input  logic [DATA_W-1:0] rd_rsp_data_i,
    input  logic              rd_rsp_err_i,
    output logic              line_valid_o,
    output logic [DATA_W-1:0] line_data_o,
    output logic              line_last_o,
    input  logic              line_ready_i,
    output logic              rd_done_o,
    output logic              rd_err_o,
    output logic              busy_o
);

    rd_state_t      state;
    rd_state_t      state_nxt;
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  total;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  rsp_cnt;
    logic              err_sticky;

    axi_rd_reqpkt_t req;
    axi_rd_rsppkt_t rsp;
    logic           rsp_take;
    logic           req_fire;
    logic           buf_valid;
    logic [1:0]     buf_count;
    logic [DATA_W-1:0] buf_data;

    assign rsp      = '{valid: rd_rsp_valid_i, data: rd_rsp_data_i, err: rd_rsp_err_i};
    // Returns are only meaningful while a read is outstanding; anything else is dropped.
    assign rsp_take = (state == ST_WAIT_RSP) && rsp.valid;
    assign req_fire = req.valid && rd_req_ready_i;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and FSM outputs. The request is held back while the buffer holds two
    // lines, which guarantees room for the single outstanding response. No push happens
    // in ISSUE, so once valid rises the buffer can only drain and valid stays up.
    always_comb begin
        state_nxt = state;
        req       = '0;
        rd_done_o = 1'b0;
        rd_err_o  = 1'b0;
        busy_o    = (state != ST_IDLE);

        if (state == ST_ISSUE && buf_count <= 2'd1) begin
            req.valid = 1'b1;
            req.addr  = line_addr(base, issue_cnt);
        end

        unique case (state)
            ST_IDLE: begin
                if (rd_trigger_i) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (req_fire) begin
                    state_nxt = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                if (rsp.valid) begin
                    state_nxt = (rsp_cnt + 7'd1 == total) ? ST_DRAIN : ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (!buf_valid) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                rd_done_o = 1'b1;
                rd_err_o  = err_sticky;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Transfer context: line-aligned base, line total, progress counters and sticky error.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            base       <= '0;
            total      <= '0;
            issue_cnt  <= '0;
            rsp_cnt    <= '0;
            err_sticky <= 1'b0;
        end else begin
            if (state == ST_IDLE && rd_trigger_i) begin
                base       <= {src_addr_i[ADDR_W-1:LINE_OFS], {LINE_OFS{1'b0}}};
                total      <= comp_decomp_i ? CNT_W'(PAGE_LINES) : CNT_W'(1);
                issue_cnt  <= '0;
                rsp_cnt    <= '0;
                err_sticky <= 1'b0;
            end
            if (req_fire) begin
                issue_cnt <= issue_cnt + 7'd1;
            end
            if (rsp_take) begin
                rsp_cnt <= rsp_cnt + 7'd1;
                if (rsp.err) begin
                    err_sticky <= 1'b1;
                end
            end
        end
    end

    hawk_linebuf2 #(
        .WIDTH(DATA_W)
    ) u_linebuf (
        .clk      (clk_i),
        .rst      (rst_i),
        .push     (rsp_take),
        .push_data(rsp.data),
        .valid    (buf_valid),
        .data     (buf_data),
        .ready    (line_ready_i),
        .count    (buf_count)
    );

    assign rd_req_valid_o = req.valid;
    assign rd_req_addr_o  = req.addr;
    assign line_valid_o   = buf_valid;
    assign line_data_o    = buf_data;
    // In DRAIN every beat has been received, so a lone remaining entry is the final one.
    assign line_last_o    = buf_valid && (state == ST_DRAIN) && (buf_count == 2'd1);

endmodule

// File: tb/tb_hawk_cmpdcmp_rd_mngr.sv
// tb/tb_hawk_cmpdcmp_rd_mngr.sv - randomized self-checking bench for hawk_cmpdcmp_rd_mngr
module tb_hawk_cmpdcmp_rd_mngr;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         rd_trigger_i;
    logic         comp_decomp_i;
    logic [47:0]  src_addr_i;
    logic         rd_req_valid_o;
    logic [47:0]  rd_req_addr_o;
    logic         rd_req_ready_i;
    logic         rd_rsp_valid_i;
    logic [511:0] rd_rsp_data_i;
    logic         rd_rsp_err_i;
    logic         line_valid_o;
    logic [511:0] line_data_o;
    logic         line_last_o;
    logic         line_ready_i;
    logic         rd_done_o;
    logic         rd_err_o;
    logic         busy_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    hawk_cmpdcmp_rd_mngr dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .rd_trigger_i  (rd_trigger_i),
        .comp_decomp_i (comp_decomp_i),
        .src_addr_i    (src_addr_i),
        .rd_req_valid_o(rd_req_valid_o),
        .rd_req_addr_o (rd_req_addr_o),
        .rd_req_ready_i(rd_req_ready_i),
        .rd_rsp_valid_i(rd_rsp_valid_i),
        .rd_rsp_data_i (rd_rsp_data_i),
        .rd_rsp_err_i  (rd_rsp_err_i),
        .line_valid_o  (line_valid_o),
        .line_data_o   (line_data_o),
        .line_last_o   (line_last_o),
        .line_ready_i  (line_ready_i),
        .rd_done_o     (rd_done_o),
        .rd_err_o      (rd_err_o),
        .busy_o        (busy_o)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory model: each line's content is a pattern derived from its own address.
    function automatic logic [511:0] beat_data(input logic [47:0] a);
        return {8{{16'hC0DE, a}}};
    endfunction

    function automatic logic [47:0] rand48();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[47:0];
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_valid"}, rd_req_valid_o, 0);
        chk({tag, "_req_addr"},  rd_req_addr_o, 0);
        chk({tag, "_line_valid"}, line_valid_o, 0);
        chk({tag, "_line_data"}, line_data_o, 0);
        chk({tag, "_line_last"}, line_last_o, 0);
        chk({tag, "_done"},      rd_done_o, 0);
        chk({tag, "_err"},       rd_err_o, 0);
        chk({tag, "_busy"},      busy_o, 0);
    endtask

    // One transfer against the reference: expected request addresses, beat order,
    // last flag, buffer occupancy and done/error are all derived from the source
    // address, the mode and the handshakes seen on the bus.
    task automatic run_xfer(input bit comp, input logic [47:0] src, input bit rand_ready,
                            input int bp_beat, input int err_beat, input int abort_beat);
        logic [47:0] ebase, exp_addr, out_addr, ba, prev_addr;
        int  etotal, issued, rsp_got, popped, occ, cd, bp_left;
        bit  outstanding, exp_err, done_seen, finished, bp_done, prev_valid, prev_ready;
        bit  rv, pop, push;
        logic [47:0] ra;

        ebase  = {src[47:6], 6'b0};
        etotal = comp ? 64 : 1;
        issued = 0; rsp_got = 0; popped = 0; occ = 0; cd = 0; bp_left = 0;
        outstanding = 0; exp_err = 0; done_seen = 0; finished = 0; bp_done = 0;
        prev_valid = 0; prev_ready = 0; prev_addr = '0; out_addr = '0;

        @(negedge clk_i);
        rd_trigger_i   = 1'b1;
        comp_decomp_i  = comp;
        src_addr_i     = src;
        rd_req_ready_i = 1'b1;
        line_ready_i   = 1'b1;
        rd_rsp_valid_i = 1'b0;
        rd_rsp_err_i   = 1'b0;
        #1;
        chk("idle_busy", busy_o, 0);
        chk("idle_req_valid", rd_req_valid_o, 0);

        for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
            @(negedge clk_i);
            if (abort_beat >= 0 && popped == abort_beat) begin
                rst_i = 1'b1; rd_trigger_i = 1'b0; rd_rsp_valid_i = 1'b0; rd_rsp_err_i = 1'b0;
                #1;
                chk_all_zero("abort_rst");
                @(negedge clk_i);
                @(negedge clk_i);
                rst_i = 1'b0;
                @(negedge clk_i);
                rd_rsp_valid_i = 1'b1; rd_rsp_data_i = beat_data(ebase); rd_rsp_err_i = 1'b1;
                #1;
                chk("late_rsp_busy", busy_o, 0);
                @(negedge clk_i);
                rd_rsp_valid_i = 1'b0; rd_rsp_err_i = 1'b0; rd_rsp_data_i = '0;
                #1;
                chk("late_rsp_dropped", line_valid_o, 0);
                chk("late_rsp_no_done", rd_done_o, 0);
                chk("late_rsp_idle", busy_o, 0);
                finished = 1;
            end else if (done_seen) begin
                rd_trigger_i = 1'b0; rd_rsp_valid_i = 1'b0;
                #1;
                chk("post_done_busy", busy_o, 0);
                chk("post_done_pulse", rd_done_o, 0);
                chk("post_done_err", rd_err_o, 0);
                finished = 1;
            end else begin
                // Drive: a stray trigger mid-transfer, line/request backpressure, read returns.
                rd_trigger_i = (cyc == 40);
                if (cyc == 40) begin
                    src_addr_i    = rand48();
                    comp_decomp_i = ~comp;
                end
                if (bp_beat >= 0 && !bp_done && popped == bp_beat) begin
                    bp_left = 20;
                    bp_done = 1;
                end
                if (bp_left > 0) begin
                    line_ready_i = 1'b0;
                    bp_left--;
                end else begin
                    line_ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
                rd_req_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (outstanding && cd == 0) begin
                    rd_rsp_valid_i = 1'b1;
                    rd_rsp_data_i  = beat_data(out_addr);
                    rd_rsp_err_i   = (rsp_got == err_beat);
                end else begin
                    rd_rsp_valid_i = 1'b0;
                    rd_rsp_err_i   = 1'b0;
                    rd_rsp_data_i  = '0;
                    if (outstanding) cd--;
                end
                #1;
                rv = rd_req_valid_o;
                ra = rd_req_addr_o;
                if (cyc == 0) chk("first_req_latency", rv, 1);
                if (prev_valid && !prev_ready) begin
                    chk("req_hold_valid", rv, 1);
                    chk("req_hold_addr", ra, prev_addr);
                end
                exp_addr = ebase + 48'(issued * 64);
                if (rv) begin
                    chk("req_addr", ra, exp_addr);
                    chk("one_outstanding", outstanding, 0);
                    chk("req_buf_le1", occ <= 1, 1);
                    chk("req_within_total", issued < etotal, 1);
                end
                chk("busy", busy_o, 1);
                chk("line_valid", line_valid_o, occ != 0);
                chk("line_last", line_last_o, (occ != 0) && (popped == etotal - 1));
                if (rd_done_o) begin
                    chk("done_beats", popped, etotal);
                    chk("done_reqs", issued, etotal);
                    chk("done_err", rd_err_o, exp_err);
                    done_seen = 1;
                end else begin
                    chk("err_outside_done", rd_err_o, 0);
                end
                pop = line_valid_o && line_ready_i;
                if (pop) begin
                    ba = ebase + 48'(popped * 64);
                    chk("beat_data", line_data_o, beat_data(ba));
                    popped++;
                end
                push = rd_rsp_valid_i;
                if (push) begin
                    rsp_got++;
                    outstanding = 0;
                    if (rd_rsp_err_i) exp_err = 1;
                end
                occ = occ + int'(push) - int'(pop);
                chk("buf_le2", occ <= 2, 1);
                if (rv && rd_req_ready_i) begin
                    outstanding = 1;
                    cd          = $urandom_range(0, 2);
                    out_addr    = exp_addr;
                    issued++;
                end
                prev_valid = rv;
                prev_ready = rd_req_ready_i;
                prev_addr  = ra;
            end
        end
        chk("xfer_completed", finished, 1);
        rd_trigger_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; rd_trigger_i = 1'b0; comp_decomp_i = 1'b0; src_addr_i = '0;
        rd_req_ready_i = 1'b0; rd_rsp_valid_i = 1'b0; rd_rsp_data_i = '0;
        rd_rsp_err_i = 1'b0; line_ready_i = 1'b0;
        #1;
        chk_all_zero("reset");
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;

        run_xfer(1'b1, 48'h1000, 1'b0, -1, -1, -1);
        run_xfer(1'b0, 48'h20047, 1'b0, -1, -1, -1);
        run_xfer(1'b1, rand48(), 1'b1, 20, -1, -1);
        run_xfer(1'b1, rand48(), 1'b0, -1, 10, -1);
        run_xfer(1'b1, rand48(), 1'b1, -1, -1, 30);
        run_xfer(1'b1, rand48(), 1'b1, -1, -1, -1);
        for (int i = 0; i < 4; i++) begin
            run_xfer(1'(i % 2), rand48(), 1'b1, -1, (i == 2) ? 0 : -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hawk_cmpdcmp_rd_mngr.md
HAWK_CMPDCMP_RD_MNGR -- requirements
Module: hawk_cmpdcmp_rd_mngr

Interface
REQ-001 SHALL have ports clk_i (in, 1, sole clock) and rst_i (in, 1, reset); one clock, and reset is asynchronous and active-high.
REQ-002 SHALL have rd_trigger_i (in, 1): starts a transfer; sampled only in IDLE.
REQ-003 SHALL have comp_decomp_i (in, 1): 1 = compress source, read a full page of 64 lines; 0 = decompress source, read 1 compressed line.
REQ-004 SHALL have src_addr_i (in, 48): source byte address, sampled with the trigger.
REQ-005 SHALL have rd_req_valid_o (out, 1), rd_req_addr_o (out, 48) and rd_req_ready_i (in, 1): read-request channel to the internal AXI read engine.
REQ-006 SHALL have rd_rsp_valid_i (in, 1), rd_rsp_data_i (in, 512) and rd_rsp_err_i (in, 1): read-data return channel; there is no ready on this channel.
REQ-007 SHALL have line_valid_o (out, 1), line_data_o (out, 512), line_last_o (out, 1) and line_ready_i (in, 1): line stream to the compressor or decompressor.
REQ-008 SHALL have rd_done_o (out, 1), rd_err_o (out, 1) and busy_o (out, 1).

Function
REQ-009 SHALL implement the states IDLE, ISSUE, WAIT_RSP, DRAIN and DONE.
REQ-010 IDLE: on rd_trigger_i, SHALL capture src_addr_i with bits [5:0] forced to 0, set total = 64 (compress) or 1 (decompress), clear the counters and the sticky error, then go to ISSUE.
REQ-011 ISSUE: SHALL assert rd_req_valid_o only while the line buffer holds at most 1 entry.
REQ-012 ISSUE: rd_req_addr_o SHALL equal base + 64*issue_cnt.
REQ-013 ISSUE: once rd_req_valid_o is asserted, it and rd_req_addr_o SHALL hold stable until rd_req_ready_i; on the handshake, issue_cnt increments and the state goes to WAIT_RSP.
REQ-014 SHALL keep at most one read outstanding.
REQ-015 WAIT_RSP: on rd_rsp_valid_i, SHALL push the data into the line buffer and increment rsp_cnt (7-bit).
REQ-016 WAIT_RSP: rd_rsp_err_i SHALL set a sticky error; the beat is still forwarded.
REQ-017 WAIT_RSP: next state SHALL be DRAIN if rsp_cnt+1 == total, else ISSUE.
REQ-018 The line buffer SHALL be a 2-entry FIFO; line_valid_o = not empty; a pop occurs on line_valid_o & line_ready_i; a simultaneous push and pop leaves the count unchanged.
REQ-019 A pushed beat SHALL appear on line_data_o no earlier than the cycle after rd_rsp_valid_i.
REQ-020 line_last_o SHALL be 1 only on the head entry that is the final beat of the transfer.
REQ-021 DRAIN: SHALL go to DONE when the buffer is empty.
REQ-022 DONE: SHALL assert rd_done_o for exactly 1 cycle with rd_err_o = sticky error in that same cycle, then go to IDLE.
REQ-023 busy_o SHALL be 1 in every state except IDLE.
REQ-024 A trigger outside IDLE SHALL be ignored.
REQ-025 rd_rsp_valid_i arriving in IDLE, ISSUE, DRAIN or DONE SHALL be dropped.
REQ-026 Buffer overflow SHALL be unreachable by construction of REQ-011; the bench asserts this.
REQ-027 Minimum latency SHALL be: trigger at cycle N, rd_req_valid_o at N+1.

Reset
REQ-028 rst_i SHALL force, asynchronously: state IDLE, all counters 0, buffer empty, sticky error 0.
REQ-029 While rst_i is asserted, all outputs SHALL be 0: rd_req_valid_o, rd_req_addr_o, line_valid_o, line_data_o, line_last_o, rd_done_o, rd_err_o, busy_o.
REQ-030 Reset mid-transfer SHALL abandon the transfer without a done pulse; a response arriving late is dropped per REQ-025.

Structure
REQ-031 hacd_pkg SHALL hold LINE_BYTES=64, PAGE_LINES=64, the state encoding, and the typedefs axi_rd_reqpkt_t (valid, addr) and axi_rd_rsppkt_t (valid, data, err), which are used for the request and response groupings.
REQ-032 The 2-entry FIFO SHALL be a sub-module, hawk_linebuf2 (parameterised width 512), and SHALL be the only sub-module.

Verification
REQ-033 Compress run, src 0x1000, ready always 1: requests go to 0x1000, 0x1040, ..., 0x1FC0 (64 of them); 64 line beats are delivered; line_last_o is set on beat 64 only; rd_done_o pulses once; rd_err_o=0.
REQ-034 Decompress run, src 0x20047: exactly one request at 0x20040; one beat with line_last_o=1; done follows after the pop.
REQ-035 Backpressure, line_ready_i=0 for 20 cycles mid-page: buffer stays at ≤2 entries; no request issues while 2 entries are held; no beat is lost or reordered.
REQ-036 rd_rsp_err_i on beat 10: all 64 beats are still delivered; rd_err_o=1 in the done cycle only.
REQ-037 Trigger pulsed during busy: no effect; the following trigger in IDLE starts normally.
REQ-038 rst_i asserted after beat 30: all outputs 0 immediately; a late rd_rsp_valid_i is ignored; a new trigger completes correctly.
